// File: rtl/vec_store_serializer_if.sv
// Control-side and memory-write-side signals of the vector store serializer.
interface vec_store_serializer_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned V  = 16,
    parameter int unsigned AW = 16
);
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [V*N-1:0]  vec_data;
    logic [V-1:0]    lane_mask;
    logic            busy;
    logic            done;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [N-1:0]    mem_wdata;
    logic            mem_ready;

    // Environment side: issues stores and plays the memory.
    modport master (
        output start, base_addr, vec_data, lane_mask, mem_ready,
        input  busy, done, mem_we, mem_addr, mem_wdata
    );

    // Serializer side.
    modport slave (
        input  start, base_addr, vec_data, lane_mask, mem_ready,
        output busy, done, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vec_store_serializer.sv
// Serializes one masked V-lane vector into per-lane byte-addressed memory writes.
// Unmasked lanes are skipped without costing a cycle.
module vec_store_serializer #(
    parameter int unsigned N  = 8,
    parameter int unsigned V  = 16,
    parameter int unsigned AW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    vec_store_serializer_if.slave bus
);
    localparam int unsigned IW = (V > 1) ? $clog2(V) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]     state, state_d;
    logic [V*N-1:0] data_q, data_d;
    logic [AW-1:0]  base_q, base_d;
    logic [V-1:0]   mask_q, mask_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [N-1:0]   wdata_q, wdata_d;
    logic           busy_q, done_q, we_q;
    int unsigned    lane_lsb;

    function automatic logic [IW-1:0] lowest_set(input logic [V-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        for (int i = int'(V) - 1; i >= 0; i--) begin
            if (m[i]) r = IW'(i);
        end
        return r;
    endfunction

    // Next-state logic; mask_q keeps only the lanes still to be written.
    always_comb begin
        state_d  = state;
        data_d   = data_q;
        base_d   = base_q;
        mask_d   = mask_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lane_lsb = 0;

        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    data_d  = bus.vec_data;
                    base_d  = bus.base_addr;
                    mask_d  = bus.lane_mask;
                    idx_d   = lowest_set(bus.lane_mask);
                    state_d = (|bus.lane_mask) ? WRITE : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (bus.mem_ready) begin
                    mask_d = mask_q & ~(V'(1) << idx_q);
                    if (|mask_d) begin
                        idx_d = lowest_set(mask_d);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Write address/data are prepared one cycle early so the port is registered.
        if (state_d == WRITE) begin
            lane_lsb = 32'(idx_d) * N;
            addr_d   = base_d + AW'(idx_d);
            wdata_d  = data_d[lane_lsb +: N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data_q  <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state   <= state_d;
            data_q  <= data_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= (state_d == WRITE);
            done_q  <= (state_d == DONE);
            we_q    <= (state_d == WRITE);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_vec_store_serializer.sv
// Scoreboard bench for vec_store_serializer: directed scenarios followed by randomized stores.
module tb_vec_store_serializer;
    localparam int unsigned N  = 8;
    localparam int unsigned V  = 16;
    localparam int unsigned AW = 16;

    localparam int MODE_ALWAYS = 0;
    localparam int MODE_RANDOM = 1;
    localparam int MODE_STALL3 = 2;

    typedef struct {
        bit            is_done;
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
        int            exp_cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   pcount = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   ready_mode = MODE_ALWAYS;
    int   stall_cnt = 0;
    ev_t  exp_q[$];

    ev_t           mon_e;
    bit            hold_valid = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [N-1:0]  hold_data;

    vec_store_serializer_if #(.N(N), .V(V), .AW(AW)) bus ();

    vec_store_serializer #(.N(N), .V(V), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcount <= pcount + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", pcount);
        $fatal(1);
    end

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, pcount);
    endtask

    task automatic randomize_inputs();
        bus.base_addr = AW'($urandom);
        bus.vec_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.lane_mask = V'($urandom);
    endtask

    // Memory model: ready behaviour set per store by ready_mode.
    initial begin
        bus.mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                MODE_ALWAYS: begin bus.mem_ready = 1'b1; stall_cnt = 0; end
                MODE_RANDOM: begin bus.mem_ready = 1'($urandom_range(0, 1)); stall_cnt = 0; end
                default: begin
                    if (bus.mem_we) begin
                        if (stall_cnt < 3) begin bus.mem_ready = 1'b0; stall_cnt++; end
                        else begin bus.mem_ready = 1'b1; stall_cnt = 0; end
                    end else begin
                        bus.mem_ready = 1'($urandom_range(0, 1));
                        stall_cnt = 0;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each accepted write and on each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            check("busy_eq_we", bus.busy, bus.mem_we);
            if (hold_valid) begin
                check("stall_we_held", bus.mem_we, 1);
                check("stall_addr_held", bus.mem_addr, hold_addr);
                check("stall_data_held", bus.mem_wdata, hold_data);
            end
            hold_valid = bus.mem_we && !bus.mem_ready;
            hold_addr  = bus.mem_addr;
            hold_data  = bus.mem_wdata;
            if (bus.mem_we && bus.mem_ready) begin
                check("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("write_order", mon_e.is_done, 0);
                    check("write_addr", bus.mem_addr, mon_e.addr);
                    check("write_data", bus.mem_wdata, mon_e.data);
                end
            end
            if (bus.done) begin
                check("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("done_order", mon_e.is_done, 1);
                    if (mon_e.exp_cyc >= 0) check("done_cycle", pcount, mon_e.exp_cyc);
                end
            end
        end
    end

    // Called at a negedge while the DUT is idle or showing done; returns at accept edge + 1.
    task automatic issue(input logic [AW-1:0] b, input logic [V*N-1:0] d, input logic [V-1:0] m);
        int  p;
        int  k;
        ev_t e;
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.vec_data  = d;
        bus.lane_mask = m;
        @(posedge clk);
        #1;
        p = pcount;
        k = $countones(m);
        for (int i = 0; i < int'(V); i++) begin
            if (m[i]) begin
                e.is_done = 1'b0;
                e.addr    = b + AW'(i);
                e.data    = d[i*N +: N];
                e.exp_cyc = -1;
                exp_q.push_back(e);
            end
        end
        e.is_done = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        case (ready_mode)
            MODE_ALWAYS: e.exp_cyc = p + k;
            MODE_STALL3: e.exp_cyc = p + 4 * k;
            default:     e.exp_cyc = -1;
        endcase
        exp_q.push_back(e);
        bus.start = 1'b0;
        randomize_inputs();
    endtask

    // Returns at the negedge of the done cycle; optionally fires start pulses while busy.
    task automatic wait_done(input bit pulse);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
            end else if (pulse && bus.busy && $urandom_range(0, 1) == 1) begin
                bus.start = 1'b1;
                randomize_inputs();
            end else begin
                bus.start = 1'b0;
            end
        end
        check("done_within_bound", seen, 1);
    endtask

    function automatic logic [V*N-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [V*N-1:0] d;
        logic [V-1:0]   m;
        rst = 1'b1;
        bus.start = 1'b0;
        randomize_inputs();
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_we", bus.mem_we, 0);
        check("reset_addr", bus.mem_addr, 0);
        check("reset_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full store, lane i = i + 0x10
        for (int i = 0; i < int'(V); i++) d[i*N +: N] = N'(i + 16);
        issue(16'h0100, d, 16'hFFFF);
        wait_done(1'b0);
        bus.start = 1'b0;
        @(negedge clk);

        // Sparse mask
        issue(16'h0020, rand_vec(), 16'h8101);
        wait_done(1'b0);
        bus.start = 1'b0;
        @(negedge clk);

        // Backpressure with ignored start pulses
        ready_mode = MODE_STALL3;
        issue(16'h0300, rand_vec(), 16'h0003);
        wait_done(1'b1);
        bus.start = 1'b0;
        ready_mode = MODE_ALWAYS;
        @(negedge clk);

        // Address wrap, then empty mask
        issue(16'hFFFE, rand_vec(), 16'h000F);
        wait_done(1'b0);
        bus.start = 1'b0;
        @(negedge clk);
        issue(AW'($urandom), rand_vec(), 16'h0000);
        wait_done(1'b0);
        bus.start = 1'b0;
        @(negedge clk);

        // Back-to-back stores
        issue(16'h1000, rand_vec(), 16'h00F0);
        wait_done(1'b0);
        issue(16'h2000, rand_vec(), 16'h0A05);
        wait_done(1'b0);
        bus.start = 1'b0;
        @(negedge clk);

        // Reset during the fifth write of a full store
        issue(16'h4000, rand_vec(), 16'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("abort_we", bus.mem_we, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        issue(16'h5000, rand_vec(), 16'h0F30);
        wait_done(1'b0);
        bus.start = 1'b0;
        @(negedge clk);

        // Randomized stores
        for (int n = 0; n < 40; n++) begin
            ready_mode = int'($urandom_range(0, 2));
            case ($urandom_range(0, 4))
                0:       m = '0;
                1:       m = V'(1) << $urandom_range(0, V - 1);
                2:       m = '1;
                default: m = V'($urandom);
            endcase
            issue(AW'($urandom), rand_vec(), m);
            wait_done(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) begin
                bus.start = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        bus.start = 1'b0;
        ready_mode = MODE_ALWAYS;
        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
